// File: rtl/legv8_alu_issue_if.sv
// Handshake bundle between decode/register-file (master) and the ALU issue stage (slave).
// The upstream valid/ready pair and the downstream valid/ready pair share one interface.
interface legv8_alu_issue_if #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  rd_data_1;
  logic [DATA_W-1:0]  rd_data_2;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         ALU_ctrl;
  logic [DATA_W-1:0]  src_1;
  logic [DATA_W-1:0]  src_2;
  logic               illegal;

  modport slave (
    input  in_valid,
    input  instr,
    input  rd_data_1,
    input  rd_data_2,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ALU_ctrl,
    output src_1,
    output src_2,
    output illegal
  );

  modport master (
    output in_valid,
    output instr,
    output rd_data_1,
    output rd_data_2,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ALU_ctrl,
    input  src_1,
    input  src_2,
    input  illegal
  );
endinterface

// File: rtl/legv8_alu_issue.sv
// LEGv8 ID/EX issue stage: opcode decode to ALU control, operand select/extend,
// and a 2-entry (output + skid) register stage so in_ready is a pure flop output.
module legv8_alu_issue #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  legv8_alu_issue_if.slave      bus
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  logic [INSTR_W-1:0] instr_s;
  logic [DATA_W-1:0]  rd1_s;
  logic [DATA_W-1:0]  rd2_s;
  logic [DATA_W-1:0]  imm_i_s;
  logic [DATA_W-1:0]  imm_d_s;
  logic               unused_instr_s;

  logic [3:0]         dec_ctrl_s;
  logic [DATA_W-1:0]  dec_src1_s;
  logic [DATA_W-1:0]  dec_src2_s;
  logic               dec_illegal_s;

  logic               accept_s;
  logic               drain_s;

  logic               out_valid_q,   out_valid_d;
  logic [3:0]         out_ctrl_q,    out_ctrl_d;
  logic [DATA_W-1:0]  out_src1_q,    out_src1_d;
  logic [DATA_W-1:0]  out_src2_q,    out_src2_d;
  logic               out_illegal_q, out_illegal_d;

  logic               skid_valid_q,   skid_valid_d;
  logic [3:0]         skid_ctrl_q,    skid_ctrl_d;
  logic [DATA_W-1:0]  skid_src1_q,    skid_src1_d;
  logic [DATA_W-1:0]  skid_src2_q,    skid_src2_d;
  logic               skid_illegal_q, skid_illegal_d;

  logic               in_ready_q,    in_ready_d;

  assign instr_s = bus.instr;
  assign rd1_s   = bus.rd_data_1;
  assign rd2_s   = bus.rd_data_2;
  // Register-number fields are resolved upstream by the register file.
  assign unused_instr_s = ^instr_s[9:0];

  assign imm_i_s = {{(DATA_W-12){1'b0}}, instr_s[21:10]};
  assign imm_d_s = {{(DATA_W-9){instr_s[20]}}, instr_s[20:12]};

  // Opcode decode: 11-bit R/D match wins, then 10-bit I, then 8-bit CB.
  always_comb begin
    dec_ctrl_s    = ALU_AND;
    dec_src1_s    = {DATA_W{1'b0}};
    dec_src2_s    = {DATA_W{1'b0}};
    dec_illegal_s = 1'b0;
    case (instr_s[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        case (instr_s[31:21])
          OP_ADD:  dec_ctrl_s = ALU_ADD;
          OP_SUB:  dec_ctrl_s = ALU_SUB;
          OP_ORR:  dec_ctrl_s = ALU_OR;
          default: dec_ctrl_s = ALU_AND;
        endcase
        dec_src1_s = rd1_s;
        dec_src2_s = rd2_s;
      end
      OP_LDUR, OP_STUR: begin
        dec_ctrl_s = ALU_ADD;
        dec_src1_s = rd1_s;
        dec_src2_s = imm_d_s;
      end
      default: begin
        case (instr_s[31:22])
          OP_ADDI: begin
            dec_ctrl_s = ALU_ADD;
            dec_src1_s = rd1_s;
            dec_src2_s = imm_i_s;
          end
          OP_SUBI: begin
            dec_ctrl_s = ALU_SUB;
            dec_src1_s = rd1_s;
            dec_src2_s = imm_i_s;
          end
          OP_ANDI: begin
            dec_ctrl_s = ALU_AND;
            dec_src1_s = rd1_s;
            dec_src2_s = imm_i_s;
          end
          OP_ORRI: begin
            dec_ctrl_s = ALU_OR;
            dec_src1_s = rd1_s;
            dec_src2_s = imm_i_s;
          end
          default: begin
            if (instr_s[31:24] == OP_CBZ) begin
              dec_ctrl_s = ALU_PASS;
              dec_src1_s = rd1_s;
              dec_src2_s = rd2_s;
            end else begin
              dec_illegal_s = 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  assign accept_s = bus.in_valid & in_ready_q;
  assign drain_s  = out_valid_q & bus.out_ready;

  // Next-state for output and skid slots; flush kills both and reopens the input.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_ctrl_d     = out_ctrl_q;
    out_src1_d     = out_src1_q;
    out_src2_d     = out_src2_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_ctrl_d    = skid_ctrl_q;
    skid_src1_d    = skid_src1_q;
    skid_src2_d    = skid_src2_q;
    skid_illegal_d = skid_illegal_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain_s) begin
      if (skid_valid_q) begin
        // in_ready was low, so nothing new can be accepted while the skid empties.
        out_valid_d   = 1'b1;
        out_ctrl_d    = skid_ctrl_q;
        out_src1_d    = skid_src1_q;
        out_src2_d    = skid_src2_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (accept_s) begin
        out_valid_d   = 1'b1;
        out_ctrl_d    = dec_ctrl_s;
        out_src1_d    = dec_src1_s;
        out_src2_d    = dec_src2_s;
        out_illegal_d = dec_illegal_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d   = 1'b1;
      skid_ctrl_d    = dec_ctrl_s;
      skid_src1_d    = dec_src1_s;
      skid_src2_d    = dec_src2_s;
      skid_illegal_d = dec_illegal_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset drops any in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_ctrl_q     <= 4'b0000;
      out_src1_q     <= {DATA_W{1'b0}};
      out_src2_q     <= {DATA_W{1'b0}};
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_ctrl_q    <= 4'b0000;
      skid_src1_q    <= {DATA_W{1'b0}};
      skid_src2_q    <= {DATA_W{1'b0}};
      skid_illegal_q <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      out_valid_q    <= out_valid_d;
      out_ctrl_q     <= out_ctrl_d;
      out_src1_q     <= out_src1_d;
      out_src2_q     <= out_src2_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_ctrl_q    <= skid_ctrl_d;
      skid_src1_q    <= skid_src1_d;
      skid_src2_q    <= skid_src2_d;
      skid_illegal_q <= skid_illegal_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_ctrl  = out_ctrl_q;
  assign bus.src_1     = out_src1_q;
  assign bus.src_2     = out_src2_q;
  assign bus.illegal   = out_illegal_q;

endmodule

// File: tb/tb_legv8_alu_issue.sv
// Directed bench for legv8_alu_issue: decode table, backpressure/skid ordering,
// flush, and asynchronous reset during a stall.
module tb_legv8_alu_issue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  legv8_alu_issue_if #(.DATA_W(64), .INSTR_W(32)) bus ();

  legv8_alu_issue #(.DATA_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [3:0]  ctrl;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rd_data_1 = r1;
    bus.rd_data_2 = r2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", bus.out_valid); n_err++; end
    n_cmp++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", bus.in_ready); n_err++; end
    n_cmp++; if (bus.ALU_ctrl !== 4'b0000) begin $display("FAIL reset_ctrl got %b want 0000", bus.ALU_ctrl); n_err++; end
    n_cmp++; if (bus.src_1 !== 64'h0 || bus.src_2 !== 64'h0) begin $display("FAIL reset_src got %h/%h want 0/0", bus.src_1, bus.src_2); n_err++; end
    n_cmp++; if (bus.illegal !== 1'b0) begin $display("FAIL reset_illegal got %b want 0", bus.illegal); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    vecs[0]  = '{32'h8B020023, 64'd5,  64'd7,  4'b0010, 64'd5,  64'd7,  1'b0};
    vecs[1]  = '{32'hCB020023, 64'd9,  64'd3,  4'b0110, 64'd9,  64'd3,  1'b0};
    vecs[2]  = '{32'h8A020023, 64'hF0, 64'h3C, 4'b0000, 64'hF0, 64'h3C, 1'b0};
    vecs[3]  = '{32'hAA020023, 64'h11, 64'h22, 4'b0001, 64'h11, 64'h22, 1'b0};
    vecs[4]  = '{32'h913FFC41, 64'd8,  64'd99, 4'b0010, 64'd8,  64'h0000000000000FFF, 1'b0};
    vecs[5]  = '{32'hD1000400, 64'd8,  64'd99, 4'b0110, 64'd8,  64'd1,  1'b0};
    vecs[6]  = '{32'h92000C00, 64'd6,  64'd99, 4'b0000, 64'd6,  64'd3,  1'b0};
    vecs[7]  = '{32'hB2002800, 64'd4,  64'd99, 4'b0001, 64'd4,  64'hA,  1'b0};
    vecs[8]  = '{32'hF85F8041, 64'h100, 64'd99, 4'b0010, 64'h100, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[9]  = '{32'hF8010041, 64'h200, 64'd99, 4'b0010, 64'h200, 64'd16, 1'b0};
    vecs[10] = '{32'hB4000041, 64'd77, 64'h1234, 4'b0111, 64'd77, 64'h1234, 1'b0};
    vecs[11] = '{32'h00000000, 64'h55, 64'h66, 4'b0000, 64'h0, 64'h0, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].r1, vecs[i].r2);
      tick();
      drive(1'b0, 32'h0, 64'h0, 64'h0);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.ALU_ctrl !== vecs[i].ctrl || bus.src_1 !== vecs[i].s1 ||
          bus.src_2 !== vecs[i].s2 || bus.illegal !== vecs[i].ill) begin
        $display("FAIL decode[%0d] got v=%b ctrl=%b s1=%h s2=%h ill=%b want v=1 ctrl=%b s1=%h s2=%h ill=%b",
                 i, bus.out_valid, bus.ALU_ctrl, bus.src_1, bus.src_2, bus.illegal,
                 vecs[i].ctrl, vecs[i].s1, vecs[i].s2, vecs[i].ill);
        n_err++;
      end
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin $display("FAIL decode_drain[%0d] got %b want 0", i, bus.out_valid); n_err++; end
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8B020023, 64'(i + 40), 64'(i));
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.src_1 !== 64'(i + 40) || bus.in_ready !== 1'b1) begin
        $display("FAIL b2b[%0d] got v=%b s1=%h rdy=%b want v=1 s1=%h rdy=1", i, bus.out_valid, bus.src_1, bus.in_ready, 64'(i + 40));
        n_err++;
      end
    end
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h8B020023, 64'd1, 64'd0);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.src_1 !== 64'd1 || bus.in_ready !== 1'b1) begin $display("FAIL bp_A got v=%b s1=%h rdy=%b want 1/1/1", bus.out_valid, bus.src_1, bus.in_ready); n_err++; end
    drive(1'b1, 32'hCB020023, 64'd2, 64'd0);
    tick();
    n_cmp++; if (bus.src_1 !== 64'd1 || bus.ALU_ctrl !== 4'b0010 || bus.in_ready !== 1'b0) begin $display("FAIL bp_skid got s1=%h ctrl=%b rdy=%b want 1/0010/0", bus.src_1, bus.ALU_ctrl, bus.in_ready); n_err++; end
    drive(1'b1, 32'hAA020023, 64'd3, 64'd0);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.src_1 !== 64'd1 || bus.in_ready !== 1'b0) begin $display("FAIL bp_hold got v=%b s1=%h rdy=%b want 1/1/0", bus.out_valid, bus.src_1, bus.in_ready); n_err++; end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.src_1 !== 64'd2 || bus.ALU_ctrl !== 4'b0110 || bus.in_ready !== 1'b1) begin $display("FAIL bp_B got v=%b s1=%h ctrl=%b rdy=%b want 1/2/0110/1", bus.out_valid, bus.src_1, bus.ALU_ctrl, bus.in_ready); n_err++; end
    tick();
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.src_1 !== 64'd3 || bus.ALU_ctrl !== 4'b0001) begin $display("FAIL bp_C got v=%b s1=%h ctrl=%b want 1/3/0001", bus.out_valid, bus.src_1, bus.ALU_ctrl); n_err++; end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin $display("FAIL bp_empty got %b want 0", bus.out_valid); n_err++; end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h8B020023, 64'd10, 64'd0);
    tick();
    drive(1'b1, 32'h8B020023, 64'd11, 64'd0);
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin $display("FAIL flush_full got rdy=%b v=%b want 0/1", bus.in_ready, bus.out_valid); n_err++; end
    drive(1'b1, 32'h8B020023, 64'd99, 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin $display("FAIL flush_kill got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); n_err++; end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin $display("FAIL flush_ghost[%0d] got v=%b s1=%h want v=0", i, bus.out_valid, bus.src_1); n_err++; end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h8B020023, 64'd20, 64'd0);
    tick();
    drive(1'b1, 32'h8B020023, 64'd21, 64'd0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin $display("FAIL async_rst got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hCB020023, 64'd30, 64'd4);
    tick();
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.ALU_ctrl !== 4'b0110 || bus.src_1 !== 64'd30 || bus.src_2 !== 64'd4) begin $display("FAIL post_rst got v=%b ctrl=%b s1=%h s2=%h want 1/0110/1e/4", bus.out_valid, bus.ALU_ctrl, bus.src_1, bus.src_2); n_err++; end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin $display("FAIL post_rst_drain got %b want 0", bus.out_valid); n_err++; end
  endtask

  initial begin
    clk   = 1'b0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/legv8_alu_issue.md
Name: legv8_alu_issue

Overview:
- ID/EX issue stage for the LEGv8 datapath: decodes the instruction opcode into the 4-bit ALU operation code, selects and extends the second operand, and registers the ALU inputs with a valid/ready handshake.
- A 2-entry skid buffer makes in_ready a pure register output. This lets the stage absorb execute-side stalls without a combinational ready path.
- Sits between the register file / decode logic and the ALU. Its outputs connect directly to the ALU's ALU_ctrl, src_1 and src_2 inputs.

Parameters:
- DATA_W, 64, operand width. Only 64 is supported.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a valid instruction and operands
- in_ready  output  1  stage can accept this cycle (registered)
- instr  input  32  LEGv8 instruction word
- rd_data_1  input  64  register-file read port 1 (Rn)
- rd_data_2  input  64  register-file read port 2 (Rm/Rt)
- flush  input  1  synchronous kill of all buffered entries
- out_valid  output  1  ALU_ctrl/src_1/src_2/illegal are valid
- out_ready  input  1  execute stage accepts the output
- ALU_ctrl  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass-src_2
- src_1  output  64  ALU operand 1
- src_2  output  64  ALU operand 2
- illegal  output  1  opcode not recognised

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, ALU_ctrl=0000, src_1=0, src_2=0, illegal=0.
  - Skid entry is invalid.
  - An operation in flight when reset asserts is lost.
- Decode (combinational on input; result is registered):
  - R-format, instr[31:21]:
    - 10001011000 (ADD) → 0010
    - 11001011000 (SUB) → 0110
    - 10001010000 (AND) → 0000
    - 10101010000 (ORR) → 0001
    - Operands: src_1=rd_data_1, src_2=rd_data_2.
  - I-format, instr[31:22]:
    - 1001000100 (ADDI) → 0010
    - 1101000100 (SUBI) → 0110
    - 1001001000 (ANDI) → 0000
    - 1011001000 (ORRI) → 0001
    - Operands: src_1=rd_data_1, src_2=zero-extended instr[21:10].
  - D-format, instr[31:21]:
    - 11111000010 (LDUR) and 11111000000 (STUR) → 0010
    - Operands: src_1=rd_data_1, src_2=sign-extended instr[20:12].
  - CB-format, instr[31:24]:
    - 10110100 (CBZ) → 0111
    - Operands: src_1=rd_data_1, src_2=rd_data_2.
  - Match priority: R/D 11-bit match first, then I 10-bit, then CB 8-bit.
  - No match: illegal=1, ALU_ctrl=0000, src_1=0, src_2=0. The entry still flows through the handshake.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Output register fields are stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle. An input accepted at edge N appears with out_valid=1 after edge N when the output register is empty or being drained.
- Skid logic, per rising edge:
  - Accept while output register is empty or drained: decoded entry loads the output register.
  - Accept while output is held (out_valid & !out_ready): entry loads the skid register; in_ready becomes 0.
  - Output drains while skid is valid: skid moves to the output register; in_ready becomes 1.
  - Simultaneous accept and drain with skid empty: new entry replaces the output entry directly.
  - in_ready = !skid_valid, registered.
  - No entry is ever dropped or duplicated. Ordering is strictly FIFO.
- Flush (highest priority, synchronous):
  - out_valid=0 and skid invalid on the next edge.
  - in_ready=1 on the next edge.
  - Any input presented in the flush cycle is discarded.
  - An output handshake completing in the flush cycle still counts as transferred.

Test Plan:
- ADD X3,X1,X2: instr=0x8B020023, rd_data_1=5, rd_data_2=7, out_ready=1 → one cycle later out_valid=1, ALU_ctrl=0010, src_1=5, src_2=7, illegal=0.
- ADDI X1,X2,#4095: instr=0x913FFC41 → ALU_ctrl=0010, src_2=0x0000000000000FFF. LDUR X1,[X2,#-8]: instr=0xF85F8041 → ALU_ctrl=0010, src_2=0xFFFFFFFFFFFFFFF8. CBZ with rd_data_2=0x1234 → ALU_ctrl=0111, src_2=0x1234.
- Backpressure: hold out_ready=0 and stream A, B, C with in_valid=1 → A held on outputs, B captured in skid, in_ready=0, C held upstream. Release out_ready → outputs A, B, C in order, no gaps after the first, none lost.
- Illegal: instr=0x00000000 → out_valid=1, illegal=1, ALU_ctrl=0000, src_1=0, src_2=0.
- Flush with output and skid both full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the presented input never appears on the outputs.
- Assert rst_n low asynchronously mid-stall → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. After release, the first accepted instruction issues normally with 1-cycle latency.
